// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the CORDIC arbiter slice.
package cordic_pkg;

    localparam int W               = 12;
    localparam int FXP_SHIFT       = 10;
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WD_BITS         = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DROP,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index strictly after pointer, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  pointer,
    output logic            grant_any,
    output logic [IDW-1:0]  grant_idx,
    output logic [NREQ-1:0] grant_onehot
);

    function automatic logic [IDW-1:0] wrap_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    logic [IDW-1:0]  cand [NREQ];
    logic [NREQ-1:0] hit;
    logic            found;

    // Candidate gi is the requester gi+1 places after the pointer, so slot 0 has top priority.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = wrap_index(pointer, gi + 1);
            assign hit[gi]  = valid[cand[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int o = 0; o < NREQ; o++) begin
            if (hit[o] && !found) begin
                grant_idx = cand[o];
                found     = 1'b1;
            end
        end
    end

    assign grant_any    = |hit;
    assign grant_onehot = grant_any ? (NREQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one start/ready CORDIC core between NREQ requesters with round-robin grant,
// tagged responses and a watchdog that resets a hung core.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = cordic_pkg::W,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_angle,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_sin,
    output logic [W-1:0]      resp_cos,
    output logic              resp_err,
    output logic              core_start,
    output logic              core_reset,
    output logic [W-1:0]      core_angle,
    input  logic              core_ready,
    input  logic [W-1:0]      core_sin,
    input  logic [W-1:0]      core_cos,
    output logic              busy
);

    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT - 1);

    state_t              state_reg;
    logic [IDW-1:0]      ptr_reg;
    logic [NREQ-1:0]     req_ready_reg;
    logic [IDW-1:0]      id_reg;
    logic [W-1:0]        angle_reg;
    logic [W-1:0]        sin_reg;
    logic [W-1:0]        cos_reg;
    logic                err_reg;
    logic                core_reset_reg;
    logic [WD_BITS-1:0]  wd_reg;

    logic                grant_any;
    logic [IDW-1:0]      grant_idx;
    logic [NREQ-1:0]     grant_onehot;
    logic [W-1:0]        angle_of [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_angle
            assign angle_of[gi] = req_angle[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .valid        (req_valid),
        .pointer      (ptr_reg),
        .grant_any    (grant_any),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= IDW'(NREQ - 1);
            req_ready_reg  <= '0;
            id_reg         <= '0;
            angle_reg      <= '0;
            sin_reg        <= '0;
            cos_reg        <= '0;
            err_reg        <= 1'b0;
            core_reset_reg <= 1'b0;
            wd_reg         <= '0;
        end else begin
            req_ready_reg  <= '0;
            core_reset_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        req_ready_reg <= grant_onehot;
                        angle_reg     <= angle_of[grant_idx];
                        id_reg        <= grant_idx;
                        ptr_reg       <= grant_idx;
                        wd_reg        <= '0;
                        state_reg     <= START;
                    end
                end
                START, BUSY: begin
                    // Ready is only trusted in BUSY, i.e. after the core has dropped a stale done flag.
                    if (state_reg == BUSY && core_ready) begin
                        sin_reg   <= core_sin;
                        cos_reg   <= core_cos;
                        err_reg   <= 1'b0;
                        state_reg <= DROP;
                    end else if (wd_reg == WD_LAST) begin
                        core_reset_reg <= 1'b1;
                        sin_reg        <= '0;
                        cos_reg        <= '0;
                        err_reg        <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        wd_reg <= wd_reg + WD_BITS'(1);
                        if (state_reg == START && !core_ready) begin
                            state_reg <= BUSY;
                        end
                    end
                end
                DROP: begin
                    state_reg <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_id    = id_reg;
    assign resp_sin   = sin_reg;
    assign resp_cos   = cos_reg;
    assign resp_err   = err_reg;
    assign core_start = (state_reg == START) || (state_reg == BUSY);
    assign core_reset = core_reset_reg;
    assign core_angle = angle_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural 30-cycle core (sin=angle, cos=~angle).
module tb_cordic_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 12;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 50;
    localparam int LATENCY = 30;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_angle;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_sin;
    logic [W-1:0]      resp_cos;
    logic              resp_err;
    logic              core_start;
    logic              core_reset;
    logic [W-1:0]      core_angle;
    logic              core_ready;
    logic [W-1:0]      core_sin;
    logic [W-1:0]      core_cos;
    logic              busy;

    always #5 clock = ~clock;

    cordic_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sin   (resp_sin),
        .resp_cos   (resp_cos),
        .resp_err   (resp_err),
        .core_start (core_start),
        .core_reset (core_reset),
        .core_angle (core_angle),
        .core_ready (core_ready),
        .core_sin   (core_sin),
        .core_cos   (core_cos),
        .busy       (busy)
    );

    // Core model: accepts start after ack_delay cycles (dropping ready), answers LATENCY cycles later,
    // then holds ready until start has gone low and a new start is accepted.
    int         ack_delay = 1;
    bit         hung = 1'b0;
    int         m_state;
    int         m_cnt;
    logic [W-1:0] m_angle;

    always @(posedge clock) begin
        if (reset || core_reset) begin
            m_state    <= 0;
            m_cnt      <= 0;
            core_ready <= 1'b0;
            core_sin   <= '0;
            core_cos   <= '0;
            m_angle    <= '0;
        end else begin
            case (m_state)
                0: begin
                    if (core_start) begin
                        if (m_cnt >= ack_delay - 1) begin
                            core_ready <= 1'b0;
                            m_angle    <= core_angle;
                            m_cnt      <= 0;
                            m_state    <= 1;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end else begin
                        m_cnt <= 0;
                    end
                end
                1: begin
                    if (!hung) begin
                        if (m_cnt == LATENCY - 1) begin
                            core_ready <= 1'b1;
                            core_sin   <= m_angle;
                            core_cos   <= ~m_angle;
                            m_cnt      <= 0;
                            m_state    <= 2;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end
                default: begin
                    if (!core_start) m_state <= 0;
                end
            endcase
        end
    end

    // Minimum low time of core_start between consecutive operations.
    int   gap_viol = 0;
    int   low_cnt  = 0;
    bit   have_prev = 1'b0;
    always @(posedge clock) begin
        if (reset) begin
            have_prev <= 1'b0;
            low_cnt   <= 0;
        end else if (core_start) begin
            if (low_cnt > 0 && have_prev && low_cnt < 2) gap_viol <= gap_viol + 1;
            have_prev <= 1'b1;
            low_cnt   <= 0;
        end else begin
            low_cnt <= low_cnt + 1;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        n_vec++;
        if (act < lim) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
        end
    endtask

    int            cyc = 0;
    int            start_cyc = 0;
    int            reset_cyc = 0;
    int            reset_len = 0;
    int            resp_cyc = 0;
    logic          prev_start = 1'b0;
    logic          prev_resp = 1'b0;
    logic [NREQ-1:0] last_grant;
    logic [W-1:0]  grant_angle;

    // One cycle: sample at the falling edge, track events, retire accepted requests.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (core_start && !prev_start) start_cyc = cyc;
        prev_start = core_start;
        if (core_reset) begin
            if (reset_len == 0) reset_cyc = cyc;
            reset_len++;
        end
        if (resp_valid && !prev_resp) resp_cyc = cyc;
        prev_resp = resp_valid;
        if (req_ready != '0) begin
            last_grant  = req_ready;
            grant_angle = core_angle;
            req_valid   = req_valid & ~req_ready;
        end
    endtask

    task automatic wait_resp(input int eid, input logic [W-1:0] eang, input logic [W-1:0] esin,
                             input logic [W-1:0] ecos, input logic eerr, input int hold);
        int            n;
        int            unstable;
        logic [NREQ-1:0] exp_g;
        logic [IDW-1:0]  s_id;
        logic [W-1:0]    s_sin;
        logic [W-1:0]    s_cos;
        logic            s_err;
        last_grant = '0;
        reset_len  = 0;
        n = 0;
        while (!resp_valid && n < 400) begin
            tick();
            n++;
        end
        if (!resp_valid) begin
            check("resp_wait_bound", 32'd0, 32'd1);
            return;
        end
        exp_g = NREQ'(1) << eid;
        check("grant_onehot", 32'(last_grant), 32'(exp_g));
        check("core_angle", 32'(grant_angle), 32'(eang));
        check("resp_id", 32'(resp_id), 32'(eid));
        check("resp_sin", 32'(resp_sin), 32'(esin));
        check("resp_cos", 32'(resp_cos), 32'(ecos));
        check("resp_err", 32'(resp_err), 32'(eerr));
        if (eerr) begin
            check("wd_reset_delay", 32'(reset_cyc - start_cyc), 32'(TIMEOUT));
            check("wd_reset_width", 32'(reset_len), 32'd1);
        end else begin
            check_ge("latency", resp_cyc - start_cyc, LATENCY);
            check("no_core_reset", 32'(reset_len), 32'd0);
        end
        if (hold > 0) begin
            unstable = 0;
            s_id = resp_id; s_sin = resp_sin; s_cos = resp_cos; s_err = resp_err;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (!resp_valid || resp_id !== s_id || resp_sin !== s_sin || resp_cos !== s_cos ||
                    resp_err !== s_err || req_ready != '0 || core_start || !busy) unstable++;
            end
            check("hold_stable", 32'(unstable), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_released", 32'(resp_valid), 32'd0);
        $display("txn id=%0d angle=0x%03h sin=0x%03h cos=0x%03h err=%0d", eid, eang, esin, ecos, eerr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_id"},    32'(resp_id), 32'd0);
        check({tag, "_resp_sin"},   32'(resp_sin), 32'd0);
        check({tag, "_resp_cos"},   32'(resp_cos), 32'd0);
        check({tag, "_resp_err"},   32'(resp_err), 32'd0);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        check({tag, "_core_angle"}, 32'(core_angle), 32'd0);
        check({tag, "_busy"},       32'(busy), 32'd0);
    endtask

    task automatic post(input int id, input logic [W-1:0] ang);
        req_angle[id*W +: W] = ang;
        req_valid[id]        = 1'b1;
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] angle;
        int           ack;
        bit           hang;
        logic [W-1:0] e_sin;
        logic [W-1:0] e_cos;
        logic         e_err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{id: 0, angle: 12'h324, ack: 1, hang: 1'b0, e_sin: 12'h324, e_cos: 12'hCDB, e_err: 1'b0};
        vecs[1] = '{id: 1, angle: 12'h0A5, ack: 1, hang: 1'b1, e_sin: 12'h000, e_cos: 12'h000, e_err: 1'b1};
        vecs[2] = '{id: 2, angle: 12'h7FF, ack: 1, hang: 1'b0, e_sin: 12'h7FF, e_cos: 12'h800, e_err: 1'b0};
        vecs[3] = '{id: 3, angle: 12'hFFF, ack: 2, hang: 1'b0, e_sin: 12'hFFF, e_cos: 12'h000, e_err: 1'b0};
        vecs[4] = '{id: 0, angle: 12'h001, ack: 1, hang: 1'b0, e_sin: 12'h001, e_cos: 12'hFFE, e_err: 1'b0};

        reset      = 1'b1;
        req_valid  = '0;
        req_angle  = '0;
        resp_ready = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // Single-request transactions: normal, hung core, stale ready, recovery.
        for (int v = 0; v < 5; v++) begin
            ack_delay = vecs[v].ack;
            hung      = vecs[v].hang;
            post(vecs[v].id, vecs[v].angle);
            wait_resp(vecs[v].id, vecs[v].angle, vecs[v].e_sin, vecs[v].e_cos, vecs[v].e_err, 0);
        end
        ack_delay = 1;
        hung      = 1'b0;

        // Back-pressure: id 2 waits behind a held response from id 1.
        post(1, 12'h2AB);
        post(2, 12'h456);
        wait_resp(1, 12'h2AB, 12'h2AB, 12'hD54, 1'b0, 20);
        wait_resp(2, 12'h456, 12'h456, 12'hBA9, 1'b0, 0);

        // All four at once from a freshly reset pointer: served 0,1,2,3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        post(0, 12'h100);
        post(1, 12'h200);
        post(2, 12'h300);
        post(3, 12'h400);
        wait_resp(0, 12'h100, 12'h100, 12'hEFF, 1'b0, 0);
        wait_resp(1, 12'h200, 12'h200, 12'hDFF, 1'b0, 0);
        wait_resp(2, 12'h300, 12'h300, 12'hCFF, 1'b0, 0);
        wait_resp(3, 12'h400, 12'h400, 12'hBFF, 1'b0, 0);

        // Reset while BUSY on id 2; pending 2 and 3 must restart from pointer NREQ-1.
        post(2, 12'h555);
        repeat (12) tick();
        check("busy_before_reset", 32'({busy, core_start}), 32'h3);
        post(2, 12'h111);
        post(3, 12'h333);
        reset = 1'b1;
        tick();
        check_reset_values("midop");
        reset = 1'b0;
        wait_resp(2, 12'h111, 12'h111, 12'hEEE, 1'b0, 0);
        wait_resp(3, 12'h333, 12'h333, 12'hCCC, 1'b0, 0);

        check("start_low_gap", 32'(gap_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one iterative sine/cosine CORDIC core (level-start / ready-hold handshake, Q2.10 12-bit angles and results) between NREQ requesters.
- Round-robin grant; latches the winner's angle, sequences the core's start/ready protocol and returns tagged results on one response channel.
- Watchdog resets a hung core and returns an error response, so the controller never deadlocks.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 12, angle/result width (Q2.10)
- IDW, 2, requester id width, equal to clog2(NREQ)
- TIMEOUT, 255, max cycles from core_start rise to core_ready; range 1..255, fits 8-bit counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request pending
- req_angle  in  NREQ*W  packed angles; requester k uses bits [k*W +: W]
- req_ready  out  NREQ  one-hot 1-cycle accept pulse
- resp_valid  out  1  result valid, held until resp_ready
- resp_ready  in  1  downstream accept
- resp_id  out  IDW  granted requester index
- resp_sin  out  W  sine result
- resp_cos  out  W  cosine result
- resp_err  out  1  1 = watchdog timeout; sin/cos forced 0
- core_start  out  1  level start to core
- core_reset  out  1  1-cycle core reset pulse
- core_angle  out  W  latched angle to core
- core_ready  in  1  core done (stays 1 until the core accepts its next start)
- core_sin  in  W  core sine
- core_cos  in  W  core cosine
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (clock is the clock; reset is synchronous, active-high): state=IDLE, rr pointer=NREQ-1, req_ready=0, resp_valid=0, resp_err=0, resp_id/sin/cos=0, core_start=0, core_reset=0, core_angle=0, watchdog=0, busy=0.
- Reset mid-operation: abandon the operation, no response, pointer back to NREQ-1.
- IDLE: if any req_valid, grant the first valid index after the pointer, modulo NREQ.
  - Same cycle: req_ready[g]=1, core_angle<=req_angle[g], resp_id<=g, pointer<=g.
  - Next state START.
  - Requests not granted stay pending; requesters must hold valid and angle until their req_ready.
- START: core_start=1, watchdog counts.
  - Stay until core_ready==0. The core clears ready only after accepting start; a stale ready from the previous op must not be taken as completion.
  - If core_ready is already 0, advance to BUSY the next cycle.
- BUSY: core_start=1, watchdog counts. On core_ready==1: capture core_sin/core_cos into resp_sin/resp_cos, resp_err<=0, go DROP.
- DROP: core_start=0 for exactly 1 cycle, then RESP.
- RESP: resp_valid=1, outputs stable; on resp_ready=1, go IDLE.
  - core_start stays low at least 2 cycles between ops (DROP + RESP). This lets the core leave its done-hold state.
- Watchdog: cleared on entering START, increments in START and BUSY.
  - On reaching TIMEOUT: core_reset=1 for 1 cycle, core_start=0, resp_sin/cos<=0, resp_err<=1, go RESP.
- Same-cycle core_ready and timeout: completion wins, no error.
- resp_ready while not in RESP: ignored.
- New req_valid during an operation: not granted until the next IDLE.
- No arithmetic on data: angles and results pass through unmodified, no sign extension.
- Ordering: exactly one response per grant, in grant order.

Decomposition:
- cordic_pkg: W, FXP_SHIFT=10, state enum {IDLE, START, BUSY, DROP, RESP}, TIMEOUT default.
- Sub-module rr_arbiter: NREQ-wide, combinational grant from (valid, pointer). Index and one-hot outputs; the pointer register stays in cordic_arbiter.

Test Plan:
- Bench uses a behavioural core model: 30-cycle latency, sin=angle, cos=~angle.
- Single request: req_valid=0001, angle 0x324 -> req_ready[0] pulse; core_angle=0x324; resp_id=0, resp_sin=0x324, resp_cos=0xCDB, resp_err=0.
- All four requesting, angles 0x100/0x200/0x300/0x400, resp_ready=1 -> grants and responses in order id 0,1,2,3, each with its own angle; core_start low ≥2 cycles between ops.
- Stale ready: model holds core_ready=1 from the previous op and clears it 2 cycles after start -> no early completion; result taken only on the next rising ready.
- Back-pressure: resp_ready=0 for 20 cycles -> resp_valid and data stable, no new grant; release -> IDLE, next grant.
- Hung core: model never raises ready, TIMEOUT=50 -> core_reset pulse at cycle 50 after start; resp_err=1, sin=cos=0; the next request completes normally.
- Reset asserted in BUSY -> all outputs at reset values next cycle; pending req 2 then granted first after pointer reset (id 0 not valid).
